// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared state encoding, SPI mode constants and bit-counter sizing for the SPI slave
package spi_slave_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/spi_slave_core_edge_det.sv
// spi_slave_edge_det: oversampled SCLK/CS edge detector mapping raw edges to sample/shift edges by CPOL/CPHA
module spi_slave_edge_det #(
  parameter int C_CPOL = 0,
  parameter int C_CPHA = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_s,
  input  logic cs_n_s,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_fall,
  output logic cs_rise
);
  logic sclk_d, cs_d, rise, fall, lead, trail;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'(C_CPOL);
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_n_s;
    end
  end
  assign rise        = sclk_s & ~sclk_d;
  assign fall        = ~sclk_s & sclk_d;
  assign lead        = (C_CPOL != 0) ? fall : rise;
  assign trail       = (C_CPOL != 0) ? rise : fall;
  assign sample_edge = (C_CPHA != 0) ? trail : lead;
  assign shift_edge  = (C_CPHA != 0) ? lead : trail;
  assign cs_fall     = cs_d & ~cs_n_s;
  assign cs_rise     = ~cs_d & cs_n_s;
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave bit engine with valid/ready word interface.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first transfers (default MSB first).
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_CPOL       = 0,
  parameter int C_CPHA       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclk_s,
  input  logic                    cs_n_s,
  input  logic                    mosi_s,
  output logic                    miso,
  output logic                    miso_oe,
  output logic [C_DATA_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [C_DATA_WIDTH-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_underrun,
  input  logic                    tx_underrun_clr
);
  localparam int CW = cnt_width(C_DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(C_DATA_WIDTH - 1);
  state_t state, state_nx;
  logic sample_edge, shift_edge, cs_fall, cs_rise;
  logic active, enter, leave, complete, load, ld_bit, tx_bit;
  logic [CW-1:0] cnt;
  logic [C_DATA_WIDTH-1:0] rx_sr, tx_sr, rx_next, ld_word, ld_rest, tx_rest;
  spi_slave_edge_det #(.C_CPOL(C_CPOL), .C_CPHA(C_CPHA)) u_edge (
    .clk(clk), .rst_n(rst_n), .sclk_s(sclk_s), .cs_n_s(cs_n_s),
    .sample_edge(sample_edge), .shift_edge(shift_edge), .cs_fall(cs_fall), .cs_rise(cs_rise)
  );
  assign ld_word = tx_valid ? tx_data : '0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next = {mosi_s, rx_sr[C_DATA_WIDTH-1:1]};
  assign ld_bit  = ld_word[0];
  assign ld_rest = ld_word >> 1;
  assign tx_bit  = tx_sr[0];
  assign tx_rest = tx_sr >> 1;
`else
  assign rx_next = {rx_sr[C_DATA_WIDTH-2:0], mosi_s};
  assign ld_bit  = ld_word[C_DATA_WIDTH-1];
  assign ld_rest = ld_word << 1;
  assign tx_bit  = tx_sr[C_DATA_WIDTH-1];
  assign tx_rest = tx_sr << 1;
`endif
  always_comb begin
    active   = state == ST_ACTIVE;
    enter    = ~active & cs_fall;
    leave    = active & cs_rise;
    complete = active & sample_edge & (cnt == LAST);
    load     = enter | (complete & ~cs_rise);
    state_nx = enter ? ST_ACTIVE : leave ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
    end else begin
      tx_ready    <= load;
      rx_valid    <= complete;
      tx_underrun <= (tx_underrun & ~tx_underrun_clr) | (load & ~tx_valid);
      if (complete) rx_data <= rx_next;
      if (active && sample_edge) rx_sr <= rx_next;
      if (leave) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        cnt     <= '0;
      end else if (enter) begin
        miso_oe <= 1'b1;
        cnt     <= '0;
        tx_sr   <= (C_CPHA == 0) ? ld_rest : ld_word;
        // leading-edge sampling needs the first bit on the wire before any SCLK edge
        if (C_CPHA == 0) miso <= ld_bit;
      end else if (active) begin
        if (sample_edge) cnt <= complete ? '0 : cnt + 1'b1;
        if (complete) tx_sr <= ld_word;
        else if (shift_edge) begin
          miso  <= tx_bit;
          tx_sr <= tx_rest;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: scoreboard bench driving one DUT per SPI mode with directed frames
module tb_spi_slave_core;
  import spi_slave_pkg::*;
  localparam int W = 8;
  typedef struct {int inst; logic [7:0] d;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, mosi = 1'b0, tx_valid = 1'b1, clr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic sclk [4];
  logic cs_n [4];
  logic miso [4], oe [4], rv [4], tr [4], ur [4];
  logic [7:0] rxd [4];
  int tr_cnt [4];
  exp_t sb [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [1:0] MD = (g == 0) ? SPI_MODE0 : (g == 1) ? SPI_MODE1 : (g == 2) ? SPI_MODE2 : SPI_MODE3;
    spi_slave_core #(.C_DATA_WIDTH(W), .C_CPOL(int'(MD[1])), .C_CPHA(int'(MD[0]))) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk_s(sclk[g]), .cs_n_s(cs_n[g]), .mosi_s(mosi),
      .miso(miso[g]), .miso_oe(oe[g]), .rx_data(rxd[g]), .rx_valid(rv[g]),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tr[g]),
      .tx_underrun(ur[g]), .tx_underrun_clr(clr)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) for (int k = 0; k < 4; k++) begin
      if (tr[k]) tr_cnt[k]++;
      if (rv[k]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected inst %0d: got %0h expected none", k, rxd[k]);
        end else begin
          e = sb.pop_front();
          chk($sformatf("rx_inst%0d", k), k, e.inst);
          chk($sformatf("rx_data%0d", k), rxd[k], e.d);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int bidx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  task automatic xfer(input int m, input logic [7:0] w, input int nb, output logic [7:0] rd);
    logic idle;
    idle = (m >= 2);
    rd = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (m % 2 == 0) begin
        mosi = w[bidx(i)];
        step(4);
        sclk[m] = ~idle;
        rd[bidx(i)] = miso[m];
        step(4);
        sclk[m] = idle;
      end else begin
        sclk[m] = ~idle;
        mosi = w[bidx(i)];
        step(4);
        sclk[m] = idle;
        rd[bidx(i)] = miso[m];
        step(4);
      end
    end
  endtask

  task automatic sel(input int m);
    int t0;
    t0 = tr_cnt[m];
    cs_n[m] = 1'b0;
    step(4);
    chk($sformatf("sel_txrdy%0d", m), tr_cnt[m] - t0, 1);
    chk($sformatf("sel_oe%0d", m), oe[m], 1'b1);
  endtask

  task automatic desel(input int m);
    step(4);
    cs_n[m] = 1'b1;
    step(4);
    chk($sformatf("desel_oe%0d", m), oe[m], 1'b0);
    chk($sformatf("desel_miso%0d", m), miso[m], 1'b0);
  endtask

  task automatic word(input int m, input logic [7:0] w, input logic [7:0] etx, input string nm);
    logic [7:0] rd;
    int t0;
    sb.push_back('{m, w});
    t0 = tr_cnt[m];
    xfer(m, w, W, rd);
    step(2);
    chk({nm, "_miso"}, rd, etx);
    chk({nm, "_reload_txrdy"}, tr_cnt[m] - t0, 1);
    chk({nm, "_rx_delivered"}, sb.size(), 0);
  endtask

  task automatic rst_vals(input int m, input string nm);
    chk({nm, "_miso"}, miso[m], 1'b0);
    chk({nm, "_oe"}, oe[m], 1'b0);
    chk({nm, "_rxd"}, rxd[m], 8'h00);
    chk({nm, "_rv"}, rv[m], 1'b0);
    chk({nm, "_tr"}, tr[m], 1'b0);
    chk({nm, "_ur"}, ur[m], 1'b0);
  endtask

  initial begin
    logic [7:0] rd;
    for (int k = 0; k < 4; k++) begin
      sclk[k] = (k >= 2);
      cs_n[k] = 1'b1;
      tr_cnt[k] = 0;
    end
    step(3);
    for (int k = 0; k < 4; k++) rst_vals(k, $sformatf("reset%0d", k));
    rst_n = 1'b1;
    step(2);
    // mode 0 single word
    tx_data = 8'hA5;
    sel(0);
    word(0, 8'h3C, 8'hA5, "m0");
    desel(0);
    // mode 3 back-to-back words
    tx_data = 8'h81;
    sel(3);
    tx_data = 8'h7E;
    word(3, 8'h12, 8'h81, "m3w0");
    word(3, 8'h34, 8'h7E, "m3w1");
    desel(3);
    // mode 1 aborted frame, then a clean one
    tx_data = 8'hC3;
    sel(1);
    xfer(1, 8'hAA, 5, rd);
    desel(1);
    sel(1);
    word(1, 8'hF0, 8'hC3, "m1");
    desel(1);
    // underrun and clear priority
    tx_valid = 1'b0;
    sel(0);
    chk("ur_set", ur[0], 1'b1);
    word(0, 8'h66, 8'h00, "ur");
    desel(0);
    chk("ur_sticky", ur[0], 1'b1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ur_cleared", ur[0], 1'b0);
    cs_n[0] = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    chk("ur_set_wins", ur[0], 1'b1);
    desel(0);
    tx_valid = 1'b1;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ur_cleared2", ur[0], 1'b0);
    // mode 2 async reset mid-frame
    tx_data = 8'h96;
    sel(2);
    word(2, 8'hC3, 8'h96, "m2a");
    desel(2);
    tx_valid = 1'b0;
    sel(2);
    xfer(2, 8'hFF, 3, rd);
    rst_n = 1'b0;
    #1;
    rst_vals(2, "midreset");
    cs_n[2] = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(2);
    tx_valid = 1'b1;
    tx_data = 8'h69;
    sel(2);
    word(2, 8'h5A, 8'h69, "m2b");
    desel(2);
    // bit order: first bit on the wire
    tx_data = 8'h01;
    sel(0);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    chk("first_bit", miso[0], 1'b1);
`else
    chk("first_bit", miso[0], 1'b0);
`endif
    word(0, 8'h01, 8'h01, "bitord");
    desel(0);
    step(10);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
